// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
// The slave modport is the decode stage; the master modport is its surroundings (fetch and execute).
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_rd_we;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
           out_rd, out_opcode, out_funct3, out_funct7, out_rd_we
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
           out_rd, out_opcode, out_funct3, out_funct7, out_rd_we
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I-style decode stage: field and immediate decode, a busy-bit scoreboard and a registered output slot.
// Optional macro DECODE_BYPASS_EN lets a same-cycle writeback feed a busy source instead of stalling.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  decode_stage_if.slave   bus,
  output logic [4:0]      rf_rd_addr1,
  output logic [4:0]      rf_rd_addr2,
  input  logic [XLEN-1:0] rf_rd_data1,
  input  logic [XLEN-1:0] rf_rd_data2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            writes_op;
  logic            rd_we;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;

  logic [31:0]           busy_reg;
  logic [31:0]           busy_next;
  logic [1:0]            src_use;
  logic [1:0]            src_stall;
  logic [1:0][4:0]       src_addr;
  logic [1:0][XLEN-1:0]  src_rf;
  logic [1:0][XLEN-1:0]  src_val;
  logic                  hazard;
  logic                  fire;

  assign instr       = bus.in_instr;
  assign opcode      = instr[6:0];
  assign rd          = instr[11:7];
  assign rf_rd_addr1 = instr[19:15];
  assign rf_rd_addr2 = instr[24:20];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_op = 1'b0;
    imm32     = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        uses_rs1  = 1'b1;
        writes_op = 1'b1;
        imm32     = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_REG: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_op = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        writes_op = 1'b1;
        imm32     = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        writes_op = 1'b1;
        imm32     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign rd_we = writes_op && (rd != 5'd0);

  // Widen the 32-bit immediate to the datapath width with sign extension.
  generate
    if (XLEN > 32) begin : g_imm_wide
      assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_imm_narrow
      assign imm_ext = imm32[XLEN-1:0];
    end
  endgenerate

  assign src_use[0]  = uses_rs1;
  assign src_use[1]  = uses_rs2;
  assign src_addr[0] = rf_rd_addr1;
  assign src_addr[1] = rf_rd_addr2;
  assign src_rf[0]   = rf_rd_data1;
  assign src_rf[1]   = rf_rd_data2;

  // x0 and unused sources always capture zero, whatever the register file returns.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic live;
      assign live = src_use[gi] && (src_addr[gi] != 5'd0);
`ifdef DECODE_BYPASS_EN
      logic byp;
      assign byp           = wb_valid && (wb_addr == src_addr[gi]);
      assign src_stall[gi] = live && busy_reg[src_addr[gi]] && !byp;
      assign src_val[gi]   = !live ? '0 : (byp ? wb_data : src_rf[gi]);
`else
      assign src_stall[gi] = live && busy_reg[src_addr[gi]];
      assign src_val[gi]   = live ? src_rf[gi] : '0;
`endif
    end
  endgenerate

`ifndef DECODE_BYPASS_EN
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  assign hazard       = bus.in_valid && ((|src_stall) || (rd_we && busy_reg[rd]));
  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
  assign fire         = bus.in_valid && bus.in_ready;

  // Set beats clear so a new writer issued alongside the old writer's writeback stays tracked.
  assign busy_next[0] = 1'b0;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (fire && rd_we && (rd == 5'(gi))) ||
                             (busy_reg[gi] && !(wb_valid && (wb_addr == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_pc      <= '0;
      bus.out_rs1_val <= '0;
      bus.out_rs2_val <= '0;
      bus.out_imm     <= '0;
      bus.out_rd      <= '0;
      bus.out_opcode  <= '0;
      bus.out_funct3  <= '0;
      bus.out_funct7  <= '0;
      bus.out_rd_we   <= 1'b0;
    end else if (fire) begin
      bus.out_valid   <= 1'b1;
      bus.out_pc      <= bus.in_pc;
      bus.out_rs1_val <= src_val[0];
      bus.out_rs2_val <= src_val[1];
      bus.out_imm     <= imm_ext;
      bus.out_rd      <= rd;
      bus.out_opcode  <= opcode;
      bus.out_funct3  <= instr[14:12];
      bus.out_funct7  <= instr[31:25];
      bus.out_rd_we   <= rd_we;
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a table of single-instruction decode vectors plus
// hand-written hazard, back-pressure, scoreboard and reset sequences.
module tb_decode_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4:0]      rf_rd_addr1, rf_rd_addr2;
  logic [XLEN-1:0] rf_rd_data1, rf_rd_data2;
  logic            wb_valid;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(XLEN)) bus ();

  decode_stage #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_rd_data1 (rf_rd_data1),
    .rf_rd_data2 (rf_rd_data2),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic        rs1_rf;  // 1: operand 1 expected from rf_rd_data1, else 0
    logic        rs2_rf;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } vec_t;

  localparam int NVEC = 13;
  localparam logic [31:0] RF1 = 32'hDEADBEEF;
  localparam logic [31:0] RF2 = 32'h0BADF00D;
  vec_t vecs [NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [31:0] exp_pc;

    //           instr          imm            rd  we rs1 rs2 f3  f7
    vecs[0]  = '{32'h00500093, 32'h00000005,  1, 1, 0, 0, 0, 7'h00}; // addi x1,x0,5
    vecs[1]  = '{32'h007302B3, 32'h00000000,  5, 1, 1, 1, 0, 7'h00}; // add x5,x6,x7
    vecs[2]  = '{32'h40A48433, 32'h00000000,  8, 1, 1, 1, 0, 7'h20}; // sub x8,x9,x10
    vecs[3]  = '{32'hFEB62C23, 32'hFFFFFFF8, 24, 0, 1, 1, 2, 7'h7F}; // sw x11,-8(x12)
    vecs[4]  = '{32'hFE000EE3, 32'hFFFFFFFC, 29, 0, 0, 0, 0, 7'h7F}; // beq x0,x0,-4
    vecs[5]  = '{32'h123456B7, 32'h12345000, 13, 1, 0, 0, 5, 7'h09}; // lui x13
    vecs[6]  = '{32'hFFFFF717, 32'hFFFFF000, 14, 1, 0, 0, 7, 7'h7F}; // auipc x14
    vecs[7]  = '{32'h0080006F, 32'h00000008,  0, 0, 0, 0, 0, 7'h00}; // jal x0,+8
    vecs[8]  = '{32'h801FF1EF, 32'hFFFFF800,  3, 1, 0, 0, 7, 7'h40}; // jal x3,-2048
    vecs[9]  = '{32'h010107E7, 32'h00000010, 15, 1, 1, 0, 0, 7'h00}; // jalr x15,16(x2)
    vecs[10] = '{32'hFFF22803, 32'hFFFFFFFF, 16, 1, 1, 0, 2, 7'h7F}; // lw x16,-1(x4)
    vecs[11] = '{32'h00A302FF, 32'h00000000,  5, 0, 0, 0, 0, 7'h00}; // unknown opcode
    vecs[12] = '{32'h00108013, 32'h00000001,  0, 0, 1, 0, 0, 7'h00}; // addi x0,x1,1

    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b1;
    rf_rd_data1   = '0;
    rf_rd_data2   = '0;
    wb_valid      = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;

    // Reset state
    cyc();
    cyc();
    chk("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset out_imm", {32'd0, bus.out_imm}, 64'd0);
    chk("reset busy", {32'd0, dut.busy_reg}, 64'd0);
    chk("reset in_ready", {63'd0, bus.in_ready}, 64'd1);
    rst_n = 1'b1;
    cyc();

    // Table: issue each vector, then drain it while retiring its rd
    for (int i = 0; i < NVEC; i++) begin
      ins           = vecs[i].instr;
      exp_pc        = 32'h1000 + 32'(4 * i);
      bus.in_valid  = 1'b1;
      bus.in_instr  = ins;
      bus.in_pc     = exp_pc;
      rf_rd_data1   = RF1;
      rf_rd_data2   = RF2;
      bus.out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d rf_rd_addr1", i), {59'd0, rf_rd_addr1}, {59'd0, ins[19:15]});
      chk($sformatf("v%0d rf_rd_addr2", i), {59'd0, rf_rd_addr2}, {59'd0, ins[24:20]});
      chk($sformatf("v%0d in_ready", i), {63'd0, bus.in_ready}, 64'd1);
      cyc();
      bus.in_valid = 1'b0;
      wb_valid     = 1'b1;
      wb_addr      = vecs[i].rd;
      wb_data      = '0;
      chk($sformatf("v%0d out_valid", i), {63'd0, bus.out_valid}, 64'd1);
      chk($sformatf("v%0d out_pc", i), {32'd0, bus.out_pc}, {32'd0, exp_pc});
      chk($sformatf("v%0d out_rs1_val", i), {32'd0, bus.out_rs1_val}, {32'd0, vecs[i].rs1_rf ? RF1 : 32'd0});
      chk($sformatf("v%0d out_rs2_val", i), {32'd0, bus.out_rs2_val}, {32'd0, vecs[i].rs2_rf ? RF2 : 32'd0});
      chk($sformatf("v%0d out_imm", i), {32'd0, bus.out_imm}, {32'd0, vecs[i].imm});
      chk($sformatf("v%0d out_rd", i), {59'd0, bus.out_rd}, {59'd0, vecs[i].rd});
      chk($sformatf("v%0d out_opcode", i), {57'd0, bus.out_opcode}, {57'd0, ins[6:0]});
      chk($sformatf("v%0d out_funct3", i), {61'd0, bus.out_funct3}, {61'd0, vecs[i].f3});
      chk($sformatf("v%0d out_funct7", i), {57'd0, bus.out_funct7}, {57'd0, vecs[i].f7});
      chk($sformatf("v%0d out_rd_we", i), {63'd0, bus.out_rd_we}, {63'd0, vecs[i].we});
      chk($sformatf("v%0d busy", i), {32'd0, dut.busy_reg},
          {32'd0, vecs[i].we ? (32'd1 << vecs[i].rd) : 32'd0});
      $display("vector %0d instr=%h imm=%h rd=%0d we=%0d", i, ins, bus.out_imm, bus.out_rd, bus.out_rd_we);
      cyc();
      wb_valid = 1'b0;
    end
    chk("table busy cleared", {32'd0, dut.busy_reg}, 64'd0);

    // addi x1,x0,5 then dependent add x2,x1,x1
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00500093;
    bus.in_pc    = 32'h100;
    rf_rd_data1  = 32'hDEADBEEF;
    cyc();
    bus.in_instr = 32'h00108133;
    bus.in_pc    = 32'h104;
    rf_rd_data1  = '0;
    rf_rd_data2  = '0;
    chk("addi out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("addi out_rd", {59'd0, bus.out_rd}, 64'd1);
    chk("addi out_imm", {32'd0, bus.out_imm}, 64'd5);
    chk("addi out_rs1_val", {32'd0, bus.out_rs1_val}, 64'd0);
    chk("addi out_rd_we", {63'd0, bus.out_rd_we}, 64'd1);
    chk("addi busy", {32'd0, dut.busy_reg}, 64'h2);
    $display("addi x1,x0,5 issued, busy=%h", dut.busy_reg);
    #1;
    chk("raw stall c1 in_ready", {63'd0, bus.in_ready}, 64'd0);
    cyc();
    #1;
    chk("raw stall c2 in_ready", {63'd0, bus.in_ready}, 64'd0);
    cyc();
    wb_valid = 1'b1;
    wb_addr  = 5'd1;
    wb_data  = 32'd5;
    #1;
`ifdef DECODE_BYPASS_EN
    chk("raw wb cycle in_ready", {63'd0, bus.in_ready}, 64'd1);
    cyc();
    wb_valid = 1'b0;
`else
    chk("raw wb cycle in_ready", {63'd0, bus.in_ready}, 64'd0);
    cyc();
    wb_valid    = 1'b0;
    rf_rd_data1 = 32'd5;
    rf_rd_data2 = 32'd5;
    #1;
    chk("raw after wb in_ready", {63'd0, bus.in_ready}, 64'd1);
    cyc();
`endif
    bus.in_valid = 1'b0;
    chk("add out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("add out_rs1_val", {32'd0, bus.out_rs1_val}, 64'd5);
    chk("add out_rs2_val", {32'd0, bus.out_rs2_val}, 64'd5);
    chk("add out_rd", {59'd0, bus.out_rd}, 64'd2);
    chk("add busy", {32'd0, dut.busy_reg}, 64'h4);
    $display("add x2,x1,x1 issued, rs1=%0d rs2=%0d", bus.out_rs1_val, bus.out_rs2_val);

    // Back-pressure for three cycles, then back-to-back transfers
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00700313;  // addi x6,x0,7
    bus.in_pc     = 32'h200;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold c%0d in_ready", c), {63'd0, bus.in_ready}, 64'd0);
      chk($sformatf("hold c%0d out_valid", c), {63'd0, bus.out_valid}, 64'd1);
      chk($sformatf("hold c%0d out_rd", c), {59'd0, bus.out_rd}, 64'd2);
      chk($sformatf("hold c%0d out_pc", c), {32'd0, bus.out_pc}, 64'h104);
      chk($sformatf("hold c%0d out_rs1_val", c), {32'd0, bus.out_rs1_val}, 64'd5);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release in_ready", {63'd0, bus.in_ready}, 64'd1);
    cyc();
    chk("b2b1 out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("b2b1 out_rd", {59'd0, bus.out_rd}, 64'd6);
    chk("b2b1 out_imm", {32'd0, bus.out_imm}, 64'd7);
    bus.in_instr = 32'h00900393;  // addi x7,x0,9
    bus.in_pc    = 32'h204;
    #1;
    chk("b2b2 in_ready", {63'd0, bus.in_ready}, 64'd1);
    cyc();
    bus.in_valid = 1'b0;
    chk("b2b2 out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("b2b2 out_rd", {59'd0, bus.out_rd}, 64'd7);
    chk("b2b2 out_pc", {32'd0, bus.out_pc}, 64'h204);
    $display("back-to-back transfers done, busy=%h", dut.busy_reg);
    cyc();
    chk("drain out_valid", {63'd0, bus.out_valid}, 64'd0);

    // Same-cycle writeback and new writer of x3: set wins
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00100193;  // addi x3,x0,1
    wb_valid     = 1'b1;
    wb_addr      = 5'd3;
    wb_data      = '0;
    #1;
    chk("x3 issue in_ready", {63'd0, bus.in_ready}, 64'd1);
    cyc();
    chk("x3 busy after set+clear", {63'd0, dut.busy_reg[3]}, 64'd1);
    // WAW: second writer of x3 stalls even with a writeback to x3 this cycle
    bus.in_instr = 32'h00200193;  // addi x3,x0,2
    #1;
    chk("waw in_ready", {63'd0, bus.in_ready}, 64'd0);
    cyc();
    wb_valid = 1'b0;
    chk("x3 busy cleared", {63'd0, dut.busy_reg[3]}, 64'd0);
    #1;
    chk("waw resolved in_ready", {63'd0, bus.in_ready}, 64'd1);
    cyc();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("x3 second out_imm", {32'd0, bus.out_imm}, 64'd2);
    chk("x3 second busy", {63'd0, dut.busy_reg[3]}, 64'd1);
    $display("x3 scoreboard sequence done, busy=%h", dut.busy_reg);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("async rst out_imm", {32'd0, bus.out_imm}, 64'd0);
    chk("async rst out_rd", {59'd0, bus.out_rd}, 64'd0);
    chk("async rst busy", {32'd0, dut.busy_reg}, 64'd0);
    chk("async rst in_ready", {63'd0, bus.in_ready}, 64'd1);
    $display("async reset applied mid-cycle");
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, default 32, width of operand, PC and immediate datapaths; instruction width is fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1 / in_ready  output  1  fetch-side handshake; transfer when both are high at a rising edge.
REQ-005 in_instr  input  32 / in_pc  input  XLEN  instruction word and its PC.
REQ-006 rf_rd_addr1, rf_rd_addr2  output  5 / rf_rd_data1, rf_rd_data2  input  XLEN  register-file combinational read port.
REQ-007 wb_valid  input  1 / wb_addr  input  5 / wb_data  input  XLEN  writeback write; same values as the register-file write port.
REQ-008 out_valid  output  1 / out_ready  input  1  execute-side handshake.
REQ-009 out_pc, out_rs1_val, out_rs2_val, out_imm  output  XLEN / out_rd  output  5 / out_opcode  output  7 / out_funct3  output  3 / out_funct7  output  7 / out_rd_we  output  1  registered decode result.

Function
REQ-010 rf_rd_addr1 SHALL equal in_instr[19:15] and rf_rd_addr2 SHALL equal in_instr[24:20] combinationally.
REQ-011 Source use SHALL be as follows: rs1 is used by opcodes 0x03, 0x13, 0x23, 0x33, 0x63 and 0x67; rs2 is used by 0x23, 0x33 and 0x63; no other opcode uses rs1 or rs2.
REQ-012 out_rd_we SHALL be 1 for opcodes 0x03, 0x13, 0x33, 0x37, 0x17, 0x6F and 0x67 when rd != 0, and 0 otherwise, including for unknown opcodes.
REQ-013 out_imm SHALL be sign-extended per format: I for 0x03/0x13/0x67, S for 0x23, B for 0x63, U for 0x37/0x17, J for 0x6F; all other opcodes give 0.
REQ-014 Scoreboard: 32 busy bits; bit 0 SHALL be hardwired to 0.
REQ-015 On transfer with out_rd_we=1, busy[rd] SHALL set; on wb_valid with wb_addr != 0, busy[wb_addr] SHALL clear; if set and clear target the same register in one cycle, set SHALL win.
REQ-016 hazard SHALL be asserted when in_valid is high and any of the following holds: a used source register is busy, or the instruction writes rd and busy[rd] is set (WAW).
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !hazard.
REQ-018 On transfer, all out_* fields SHALL register at that edge, and out_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-019 out_valid with out_ready=0 SHALL hold every out_* field stable; out_ready=1 with no new transfer SHALL clear out_valid.
REQ-020 Transfer and drain in the same cycle SHALL keep out_valid at 1 with the new payload, giving full throughput.
REQ-021 A source register of 0 SHALL capture the value 0, regardless of rf_rd_data (x0 storage is not reset).
REQ-022 An unused source SHALL capture 0.

Reset
REQ-023 While rst_n=0: out_valid=0, all out_* fields=0, all busy bits=0; this SHALL apply immediately, without a clock edge.
REQ-024 Reset asserted mid-operation SHALL discard the held payload and the scoreboard; in_ready SHALL follow REQ-017 from the reset state.

Configuration
REQ-025 Macro DECODE_BYPASS_EN SHALL control writeback bypass.
REQ-026 When defined: a source register that is busy only, with wb_valid=1 and wb_addr equal to it in the same cycle, SHALL not raise hazard; the captured value SHALL be wb_data.
REQ-027 When undefined: the REQ-026 case SHALL stall one cycle; the operand SHALL then be read from rf_rd_data after the register-file write.
REQ-028 The macro SHALL NOT change WAW stalling or x0 handling.

Verification
REQ-029 Reset, then addi x1,x0,5 (0x00500093) -> next cycle out_valid=1, out_rd=1, out_imm=5, out_rs1_val=0, out_rd_we=1, busy[1]=1.
REQ-030 add x2,x1,x1 while busy[1]=1, no wb -> in_ready=0 each cycle; wb x1=5 -> with macro: accepted the same cycle, out_rs1_val=out_rs2_val=5; without macro: accepted one cycle later, both values 5.
REQ-031 Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; then out_ready=1 with new in_valid -> back-to-back transfer, out_valid stays 1.
REQ-032 beq with imm -4 (0xFE000EE3) -> out_imm=0xFFFFFFFC, out_rd_we=0, no busy bit set.
REQ-033 rf_rd_data1=0xDEADBEEF while addr1=0 -> captured operand 0.
REQ-034 Same-cycle wb to x3 and issue of a new x3 writer (busy[3]=0 at issue) -> busy[3]=1 afterwards; assert rst_n=0 mid-stream -> out_valid=0 and busy=0 immediately.
